// File: rtl/vproc_result_queue.sv
// Commit-gated result FIFO between the vector unit's writeback path and the host result channel.
// Optional macro VPROC_RESULT_BYPASS_EN: committed results entering an empty queue are offered in the same cycle.
module vproc_result_queue #(
    parameter int unsigned X_ID_WIDTH  = 3,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                       clk_i,
    input  logic                       async_rst_i,
    input  logic                       commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]      commit_id_i,
    input  logic                       commit_kill_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [X_ID_WIDTH-1:0]      enq_id_i,
    input  logic [X_RFW_WIDTH-1:0]     enq_data_i,
    input  logic [4:0]                 enq_rd_i,
    input  logic [X_RFW_WIDTH/32-1:0]  enq_we_i,
    input  logic                       enq_exc_i,
    input  logic [5:0]                 enq_exccode_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [X_ID_WIDTH-1:0]      result_id_o,
    output logic [X_RFW_WIDTH-1:0]     result_data_o,
    output logic [4:0]                 result_rd_o,
    output logic [X_RFW_WIDTH/32-1:0]  result_we_o,
    output logic                       result_exc_o,
    output logic [5:0]                 result_exccode_o,
    output logic                       result_err_o,
    output logic                       result_dbg_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned WE_W  = X_RFW_WIDTH / 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned N_ID  = 2 ** X_ID_WIDTH;

    typedef enum logic [1:0] {
        HEAD_WAIT  = 2'd0,
        HEAD_OFFER = 2'd1,
        HEAD_DROP  = 2'd2
    } head_state_e;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic [WE_W-1:0]        we;
        logic                   exc;
        logic [5:0]             exccode;
    } entry_t;

    entry_t            mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [N_ID-1:0]   cmt_r;
    logic [N_ID-1:0]   kill_r;
    logic [N_ID-1:0]   cmt_nxt_s;
    logic [N_ID-1:0]   kill_nxt_s;

    entry_t            head_s;
    entry_t            enq_entry_s;
    head_state_e       head_state_s;
    logic              empty_s;
    logic              byp_s;
    logic              enq_fire_s;
    logic              wr_en_s;
    logic              pop_s;
    logic              clr_cmt_s;
    logic [X_ID_WIDTH-1:0] clr_cmt_id_s;
    logic              clr_kill_s;

    assign head_s      = mem_r[rd_ptr_r];
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign enq_ready_o = (count_r != CNT_W'(DEPTH));
    assign enq_fire_s  = enq_valid_i && enq_ready_o;
    assign enq_entry_s = '{id: enq_id_i, data: enq_data_i, rd: enq_rd_i,
                           we: enq_we_i, exc: enq_exc_i, exccode: enq_exccode_i};

`ifdef VPROC_RESULT_BYPASS_EN
    assign byp_s = empty_s && enq_valid_i && cmt_r[enq_id_i];
`else
    assign byp_s = 1'b0;
`endif

    // Head decision from registered state only; a committed head stays offered even if a kill arrives later.
    always_comb begin
        head_state_s = HEAD_WAIT;
        if (empty_s) begin
            head_state_s = HEAD_WAIT;
        end else if (cmt_r[head_s.id]) begin
            head_state_s = HEAD_OFFER;
        end else if (kill_r[head_s.id]) begin
            head_state_s = HEAD_DROP;
        end else begin
            head_state_s = HEAD_WAIT;
        end
    end

    assign pop_s        = ((head_state_s == HEAD_OFFER) && result_ready_i) || (head_state_s == HEAD_DROP);
    assign clr_cmt_s    = ((head_state_s == HEAD_OFFER) || byp_s) && result_ready_i;
    assign clr_cmt_id_s = byp_s ? enq_id_i : head_s.id;
    assign clr_kill_s   = (head_state_s == HEAD_DROP);
    // A bypassed result accepted in the same cycle never needs a slot.
    assign wr_en_s      = enq_fire_s && !(byp_s && result_ready_i);

    // Next commit table: clears from retiring entries, then new commits, so a set wins on a collision.
    always_comb begin
        cmt_nxt_s  = cmt_r;
        kill_nxt_s = kill_r;
        for (int unsigned i = 0; i < N_ID; i++) begin
            cmt_nxt_s[i]  = (commit_valid_i && !commit_kill_i && (commit_id_i == X_ID_WIDTH'(i))) ? 1'b1 :
                            (clr_cmt_s && (clr_cmt_id_s == X_ID_WIDTH'(i))) ? 1'b0 : cmt_r[i];
            kill_nxt_s[i] = (commit_valid_i && commit_kill_i && (commit_id_i == X_ID_WIDTH'(i))) ? 1'b1 :
                            (clr_kill_s && (head_s.id == X_ID_WIDTH'(i))) ? 1'b0 : kill_r[i];
        end
    end

    // Commit table state.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            cmt_r  <= {N_ID{1'b0}};
            kill_r <= {N_ID{1'b0}};
        end else begin
            cmt_r  <= cmt_nxt_s;
            kill_r <= kill_nxt_s;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= enq_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Result channel drive: head entry, or the incoming entry when bypassing.
    always_comb begin
        result_valid_o   = 1'b0;
        result_id_o      = head_s.id;
        result_data_o    = head_s.data;
        result_rd_o      = head_s.rd;
        result_we_o      = head_s.we;
        result_exc_o     = head_s.exc;
        result_exccode_o = head_s.exccode;
        if (byp_s) begin
            result_valid_o   = 1'b1;
            result_id_o      = enq_entry_s.id;
            result_data_o    = enq_entry_s.data;
            result_rd_o      = enq_entry_s.rd;
            result_we_o      = enq_entry_s.we;
            result_exc_o     = enq_entry_s.exc;
            result_exccode_o = enq_entry_s.exccode;
        end else begin
            result_valid_o   = (head_state_s == HEAD_OFFER);
        end
    end

    assign result_err_o = 1'b0;
    assign result_dbg_o = 1'b0;
    assign count_o      = count_r;

endmodule
